// File: rtl/mc_defs.sv
// Shared definitions for the multicycle control unit:
// state codes, ALU codes, opcodes/functs and select encodings.
package mc_defs;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_RS  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [1:0] B_RT   = 2'b00;
  localparam logic [1:0] B_FOUR = 2'b01;
  localparam logic [1:0] B_IMM  = 2'b10;
  localparam logic [1:0] B_IMM2 = 2'b11;

  typedef struct packed {
    logic r_add;
    logic r_sub;
    logic r_and;
    logic r_or;
    logic r_xor;
    logic r_sll;
    logic r_srl;
    logic r_sra;
    logic r_jr;
    logic i_addi;
    logic i_andi;
    logic i_ori;
    logic i_xori;
    logic i_lui;
    logic i_lw;
    logic i_sw;
    logic i_beq;
    logic i_bne;
    logic i_j;
    logic i_jal;
  } inst_t;

endpackage

// File: rtl/mc_decode.sv
// Instruction decoder: op/func to a one-hot class,
// plus an illegal flag when nothing matches.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output inst_t      inst,
  output logic       illegal
);

  always_comb begin
    inst = '0;
    unique case (op)
      OP_R: begin
        unique case (func)
          F_ADD:   inst.r_add = 1'b1;
          F_SUB:   inst.r_sub = 1'b1;
          F_AND:   inst.r_and = 1'b1;
          F_OR:    inst.r_or  = 1'b1;
          F_XOR:   inst.r_xor = 1'b1;
          F_SLL:   inst.r_sll = 1'b1;
          F_SRL:   inst.r_srl = 1'b1;
          F_SRA:   inst.r_sra = 1'b1;
          F_JR:    inst.r_jr  = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: inst.i_addi = 1'b1;
      OP_ANDI: inst.i_andi = 1'b1;
      OP_ORI:  inst.i_ori  = 1'b1;
      OP_XORI: inst.i_xori = 1'b1;
      OP_LUI:  inst.i_lui  = 1'b1;
      OP_LW:   inst.i_lw   = 1'b1;
      OP_SW:   inst.i_sw   = 1'b1;
      OP_BEQ:  inst.i_beq  = 1'b1;
      OP_BNE:  inst.i_bne  = 1'b1;
      OP_J:    inst.i_j    = 1'b1;
      OP_JAL:  inst.i_jal  = 1'b1;
      default: ;
    endcase
    illegal = ~|inst;
  end

endmodule

// File: rtl/mc_cu.sv
// Multicycle control unit: IF/ID/EXE/MEM/WB sequencer with
// memory req/ready handshake and retired-instruction counter.
module mc_cu
  import mc_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             wmem,
  output logic             wir,
  output logic             wpc,
  output logic [1:0]       pcsource,
  output logic             wreg,
  output logic             regrt,
  output logic             m2reg,
  output logic             jal,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             sext,
  output logic             shift,
  output logic [3:0]       aluc,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_t st, nxt;
  inst_t  d;
  logic   bad, retire;
  logic   req_c, wmem_c, wir_c, wpc_c, wreg_c;
  logic   i_alu, ldst;

  mc_decode u_dec (
    .op      (op),
    .func    (func),
    .inst    (d),
    .illegal (bad)
  );

  assign i_alu = d.i_addi | d.i_andi | d.i_ori
               | d.i_xori | d.i_lui;
  assign ldst  = d.i_lw | d.i_sw;
  assign state = st;

  always_comb begin
    req_c    = 1'b0;
    wmem_c   = 1'b0;
    wir_c    = 1'b0;
    wpc_c    = 1'b0;
    wreg_c   = 1'b0;
    iord     = 1'b0;
    pcsource = PC_SEQ;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = B_RT;
    sext     = 1'b0;
    shift    = 1'b0;
    aluc     = ALU_ADD;
    illegal  = 1'b0;
    retire   = 1'b0;
    nxt      = S_IF;
    case (st)
      S_IF: begin
        req_c   = 1'b1;
        alusrcb = B_FOUR;
        wpc_c   = mem_ready;
        wir_c   = mem_ready;
        nxt     = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        alusrcb = B_IMM2;
        sext    = 1'b1;
        unique case (1'b1)
          d.i_j: begin
            wpc_c    = 1'b1;
            pcsource = PC_JMP;
            retire   = 1'b1;
          end
          d.i_jal: begin
            wpc_c    = 1'b1;
            pcsource = PC_JMP;
            wreg_c   = 1'b1;
            jal      = 1'b1;
            retire   = 1'b1;
          end
          d.r_jr: begin
            wpc_c    = 1'b1;
            pcsource = PC_RS;
            retire   = 1'b1;
          end
          bad:     illegal = 1'b1;
          default: nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        alusrca = 1'b1;
        alusrcb = (i_alu | ldst) ? B_IMM : B_RT;
        shift   = d.r_sll | d.r_srl | d.r_sra;
        sext    = d.i_addi | ldst;
        unique case (1'b1)
          d.r_sub, d.i_beq, d.i_bne: aluc = ALU_SUB;
          d.r_and, d.i_andi:         aluc = ALU_AND;
          d.r_or,  d.i_ori:          aluc = ALU_OR;
          d.r_xor, d.i_xori:         aluc = ALU_XOR;
          d.i_lui:                   aluc = ALU_LUI;
          d.r_sll:                   aluc = ALU_SLL;
          d.r_srl:                   aluc = ALU_SRL;
          d.r_sra:                   aluc = ALU_SRA;
          default:                   aluc = ALU_ADD;
        endcase
        if (d.i_beq | d.i_bne) begin
          pcsource = PC_BR;
          wpc_c    = (d.i_beq & z) | (d.i_bne & ~z);
          retire   = 1'b1;
        end else begin
          nxt = ldst ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        req_c  = 1'b1;
        iord   = 1'b1;
        wmem_c = d.i_sw & mem_ready;
        if (mem_ready) begin
          nxt    = d.i_sw ? S_IF : S_WB;
          retire = d.i_sw;
        end else begin
          nxt = S_MEM;
        end
      end
      S_WB: begin
        wreg_c = 1'b1;
        regrt  = i_alu | d.i_lw;
        m2reg  = d.i_lw;
        retire = 1'b1;
      end
      default: nxt = S_IF;
    endcase
  end

  // Enables drop the moment reset rises, not at the next edge.
  assign mem_req = req_c  & ~reset;
  assign wmem    = wmem_c & ~reset;
  assign wir     = wir_c  & ~reset;
  assign wpc     = wpc_c  & ~reset;
  assign wreg    = wreg_c & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st      <= S_IF;
      instret <= '0;
    end else begin
      st <= nxt;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

endmodule
